// File: rtl/rrat_recovery_ctrl_if.sv
// Bundle between the recovery controller and the ROB retire ports, RRAT, RAT and free list.
// master: the surrounding pipeline (drives retire info and the RRAT copy).
// slave:  the recovery controller (drives write enables, rollback/restore, pushes, stall).
interface rrat_recovery_ctrl_if #(
  parameter int unsigned SCALAR         = 2,
  parameter int unsigned NUM_ENTRIES    = 32,
  parameter int unsigned PREG_IDX_WIDTH = 6
);
  logic [SCALAR-1:0]                     retire_valid;
  logic [SCALAR-1:0]                     retire_mispredict;
  logic [SCALAR-1:0]                     rrat_write_en;
  logic                                  rollback;
  logic [NUM_ENTRIES*PREG_IDX_WIDTH-1:0] rrat_tag_copy;
  logic                                  rat_restore_en;
  logic                                  squash;
  logic                                  freelist_clear;
  logic [SCALAR-1:0]                     freelist_push_valid;
  logic [SCALAR*PREG_IDX_WIDTH-1:0]      freelist_push_tag;
  logic                                  stall_dispatch;
  logic                                  recovery_done;

  modport master (
    output retire_valid, retire_mispredict, rrat_tag_copy,
    input  rrat_write_en, rollback, rat_restore_en, squash, freelist_clear,
           freelist_push_valid, freelist_push_tag, stall_dispatch, recovery_done
  );

  modport slave (
    input  retire_valid, retire_mispredict, rrat_tag_copy,
    output rrat_write_en, rollback, rat_restore_en, squash, freelist_clear,
           freelist_push_valid, freelist_push_tag, stall_dispatch, recovery_done
  );
endinterface

// File: rtl/rrat_recovery_ctrl.sv
// Branch-mispredict recovery sequencer for the retirement rename table.
// Gates RRAT write enables at retire, fires rollback/RAT restore/squash/free-list clear on a
// retiring mispredict, then rebuilds the free list by scanning SCALAR physical registers per
// cycle against an occupancy bitmap captured from the RRAT copy. Dispatch is stalled until
// the single-cycle recovery_done pulse has passed.
// Ports: clock, reset (sync, active-high), bus (slave side of rrat_recovery_ctrl_if).
module rrat_recovery_ctrl #(
  parameter int unsigned SCALAR         = 2,
  parameter int unsigned NUM_ENTRIES    = 32,
  parameter int unsigned NUM_PREGS      = 64,
  parameter int unsigned PREG_IDX_WIDTH = 6
) (
  input logic                 clock,
  input logic                 reset,
  rrat_recovery_ctrl_if.slave bus
);

  // One extra bit so scan_ptr + SCALAR can reach NUM_PREGS without wrapping.
  localparam int unsigned PtrWidth = PREG_IDX_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                    state_q, state_d;
  logic [PtrWidth-1:0]       scan_ptr_q, scan_ptr_d;
  logic [NUM_PREGS-1:0]      used_q, used_d;
  logic [SCALAR-1:0]         mispredict_hit;
  logic                      trigger;
  logic [PREG_IDX_WIDTH-1:0] lane_tag [SCALAR];

  assign mispredict_hit = bus.retire_valid & bus.retire_mispredict;
  assign trigger        = (state_q == StIdle) && (|mispredict_hit);

  // Slots younger than the oldest mispredict are wrong-path; the mispredict itself commits.
  always_comb begin
    logic older_mp;
    older_mp          = 1'b0;
    bus.rrat_write_en = '0;
    if (state_q == StIdle) begin
      for (int j = 0; j < SCALAR; j++) begin
        bus.rrat_write_en[j] = bus.retire_valid[j] & ~older_mp;
        older_mp             = older_mp | mispredict_hit[j];
      end
    end
  end

  // Occupancy of the committed mapping; duplicate tags simply set the same bit twice.
  always_comb begin
    used_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      used_d[bus.rrat_tag_copy[i*PREG_IDX_WIDTH +: PREG_IDX_WIDTH]] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    scan_ptr_d = scan_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          state_d    = StScan;
          scan_ptr_d = '0;
        end
      end
      StScan: begin
        scan_ptr_d = scan_ptr_q + PtrWidth'(SCALAR);
        if (scan_ptr_q + PtrWidth'(SCALAR) == PtrWidth'(NUM_PREGS)) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.rollback            = trigger;
    bus.rat_restore_en      = trigger;
    bus.squash              = trigger;
    bus.freelist_clear      = trigger;
    bus.stall_dispatch      = trigger | (state_q != StIdle);
    bus.recovery_done       = (state_q == StDone);
    bus.freelist_push_valid = '0;
    bus.freelist_push_tag   = '0;
    for (int k = 0; k < SCALAR; k++) begin
      lane_tag[k] = scan_ptr_q[PREG_IDX_WIDTH-1:0] + PREG_IDX_WIDTH'(k);
      if (state_q == StScan) begin
        bus.freelist_push_valid[k]                                   = ~used_q[lane_tag[k]];
        bus.freelist_push_tag[k*PREG_IDX_WIDTH +: PREG_IDX_WIDTH] = lane_tag[k];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      scan_ptr_q <= '0;
      used_q     <= '0;
    end else begin
      state_q    <= state_d;
      scan_ptr_q <= scan_ptr_d;
      if (trigger) begin
        used_q <= used_d;
      end
    end
  end

endmodule

// File: tb/tb_rrat_recovery_ctrl.sv
module tb_rrat_recovery_ctrl;
  localparam int S        = 2;
  localparam int NE       = 32;
  localparam int NP       = 64;
  localparam int W        = 6;
  localparam int SCAN_CYC = NP / S;

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  rrat_recovery_ctrl_if #(.SCALAR(S), .NUM_ENTRIES(NE), .PREG_IDX_WIDTH(W)) bus ();

  rrat_recovery_ctrl #(
    .SCALAR(S), .NUM_ENTRIES(NE), .NUM_PREGS(NP), .PREG_IDX_WIDTH(W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  // Slot j commits if valid and no older slot is a valid mispredict.
  function automatic logic [S-1:0] model_wen(input logic [S-1:0] v, input logic [S-1:0] m);
    logic [S-1:0] r;
    bit blocked;
    blocked = 0;
    for (int j = 0; j < S; j++) begin
      r[j] = v[j] && !blocked;
      if (v[j] && m[j]) blocked = 1;
    end
    return r;
  endfunction

  function automatic logic [NE*W-1:0] make_copy(input int base);
    logic [NE*W-1:0] c;
    for (int i = 0; i < NE; i++) c[i*W +: W] = W'(base + i);
    return c;
  endfunction

  function automatic logic [NE*W-1:0] rand_copy();
    logic [NE*W-1:0] c;
    for (int i = 0; i < NE; i++) c[i*W +: W] = W'($urandom_range(0, NP - 1));
    return c;
  endfunction

  // Full recovery starting next cycle (T). Checks the trigger cycle, then T+1..T+SCAN_CYC+1.
  // Expected pushes: all tags absent from the copy, ascending; tag p appears in cycle p/S+1.
  task automatic run_recovery(input string name, input logic [NE*W-1:0] copy,
                              input logic [S-1:0] v, input logic [S-1:0] m,
                              input bit inject, input int abort_at);
    int   exp_q[$];
    bit   used[NP];
    bit   aborted;
    int   tag;
    logic [S-1:0] iv;
    @(posedge clock); #1;
    bus.rrat_tag_copy     = copy;
    bus.retire_valid      = v;
    bus.retire_mispredict = m;
    for (int p = 0; p < NP; p++) used[p] = 0;
    for (int i = 0; i < NE; i++) used[int'(copy[i*W +: W])] = 1;
    for (int p = 0; p < NP; p++) if (!used[p]) exp_q.push_back(p);
    @(negedge clock);
    checks++;
    if (bus.rrat_write_en !== model_wen(v, m)) begin
      failures++;
      $display("FAIL %s trigger wen: got %b want %b", name, bus.rrat_write_en, model_wen(v, m));
    end
    checks++;
    if ({bus.rollback, bus.rat_restore_en, bus.squash, bus.freelist_clear,
         bus.stall_dispatch} !== 5'b11111) begin
      failures++;
      $display("FAIL %s trigger pulses: got %b want 11111", name,
               {bus.rollback, bus.rat_restore_en, bus.squash, bus.freelist_clear,
                bus.stall_dispatch});
    end
    checks++;
    if (bus.freelist_push_valid !== '0 || bus.recovery_done !== 1'b0) begin
      failures++;
      $display("FAIL %s trigger push/done: got %b/%b want 0/0", name,
               bus.freelist_push_valid, bus.recovery_done);
    end
    for (int c = 1; c <= SCAN_CYC + 1; c++) begin
      @(posedge clock); #1;
      reset = (abort_at > 0 && c == abort_at);
      if (inject) begin
        iv = S'($urandom);
        iv[0] = 1'b1;
        bus.retire_valid      = iv;
        bus.retire_mispredict = '1;
        bus.rrat_tag_copy     = rand_copy();
      end else begin
        bus.retire_valid      = '0;
        bus.retire_mispredict = '0;
      end
      @(negedge clock);
      aborted = (abort_at > 0 && c > abort_at);
      checks++;
      if (bus.stall_dispatch !== !aborted) begin
        failures++;
        $display("FAIL %s stall c=%0d: got %b want %b", name, c, bus.stall_dispatch, !aborted);
      end
      checks++;
      if (bus.recovery_done !== (!aborted && c == SCAN_CYC + 1)) begin
        failures++;
        $display("FAIL %s done c=%0d: got %b want %b", name, c, bus.recovery_done,
                 (!aborted && c == SCAN_CYC + 1));
      end
      checks++;
      if (bus.rollback !== 1'b0 || bus.rrat_write_en !== '0) begin
        failures++;
        $display("FAIL %s busy retire c=%0d: rollback %b wen %b want 0 0", name, c,
                 bus.rollback, bus.rrat_write_en);
      end
      for (int k = 0; k < S; k++) begin
        if (bus.freelist_push_valid[k] === 1'b1) begin
          tag = int'(bus.freelist_push_tag[k*W +: W]);
          checks++;
          if (aborted || exp_q.size() == 0) begin
            failures++;
            $display("FAIL %s spurious push c=%0d lane %0d: got tag %0d want none", name, c,
                     k, tag);
          end else begin
            if (tag !== exp_q[0] || c != exp_q[0] / S + 1) begin
              failures++;
              $display("FAIL %s push c=%0d lane %0d: got tag %0d want tag %0d at c=%0d", name,
                       c, k, tag, exp_q[0], exp_q[0] / S + 1);
            end
            void'(exp_q.pop_front());
          end
        end
      end
    end
    if (abort_at == 0) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL %s missing pushes: got %0d left want 0 (next %0d)", name, exp_q.size(),
                 exp_q[0]);
      end
    end
  endtask

  task automatic check_idle(input string name);
    @(posedge clock); #1;
    bus.retire_valid      = '0;
    bus.retire_mispredict = '0;
    reset                 = 1'b0;
    @(negedge clock);
    checks++;
    if ({bus.stall_dispatch, bus.recovery_done, bus.freelist_push_valid, bus.rollback} !== '0)
    begin
      failures++;
      $display("FAIL %s idle: stall %b done %b push %b rollback %b want all 0", name,
               bus.stall_dispatch, bus.recovery_done, bus.freelist_push_valid, bus.rollback);
    end
  endtask

  task automatic test_reset();
    reset                 = 1'b1;
    bus.retire_valid      = '0;
    bus.retire_mispredict = '0;
    bus.rrat_tag_copy     = make_copy(0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({bus.rollback, bus.rat_restore_en, bus.squash, bus.freelist_clear, bus.stall_dispatch,
         bus.recovery_done, bus.freelist_push_valid, bus.freelist_push_tag,
         bus.rrat_write_en} !== '0) begin
      failures++;
      $display("FAIL reset outputs: stall %b push %b tag %h done %b want all 0",
               bus.stall_dispatch, bus.freelist_push_valid, bus.freelist_push_tag,
               bus.recovery_done);
    end
    bus.retire_valid = 2'b11;
    #1;
    checks++;
    if (bus.rrat_write_en !== 2'b11) begin
      failures++;
      $display("FAIL reset wen follows: got %b want 11", bus.rrat_write_en);
    end
    @(posedge clock); #1;
    reset            = 1'b0;
    bus.retire_valid = '0;
  endtask

  task automatic test_wen_idle();
    logic [S-1:0] v, m;
    for (int n = 0; n < 16; n++) begin
      @(posedge clock); #1;
      v = S'($urandom);
      m = S'($urandom) & ~v;
      bus.retire_valid      = v;
      bus.retire_mispredict = m;
      @(negedge clock);
      checks++;
      if (bus.rrat_write_en !== model_wen(v, m) || bus.stall_dispatch !== 1'b0 ||
          bus.rollback !== 1'b0) begin
        failures++;
        $display("FAIL idle wen v=%b m=%b: got wen %b stall %b rb %b want %b 0 0", v, m,
                 bus.rrat_write_en, bus.stall_dispatch, bus.rollback, model_wen(v, m));
      end
    end
  endtask

  task automatic test_identity();
    run_recovery("identity", make_copy(0), 2'b01, 2'b01, 0, 0);
    check_idle("identity");
  endtask

  task automatic test_older_mispredict();
    run_recovery("older_mp", make_copy(0), 2'b11, 2'b01, 0, 0);
    check_idle("older_mp");
  endtask

  task automatic test_bypass();
    logic [NE*W-1:0] c;
    c = make_copy(0);
    c[5*W +: W] = 6'd40;
    run_recovery("bypass", c, 2'b11, 2'b10, 0, 0);
    check_idle("bypass");
  endtask

  task automatic test_scan_ignores_retire();
    run_recovery("scan_inject", make_copy(0), 2'b01, 2'b01, 1, 0);
    check_idle("scan_inject");
  endtask

  task automatic test_abort();
    run_recovery("abort", make_copy(0), 2'b01, 2'b01, 0, 10);
    check_idle("abort");
    run_recovery("after_abort", make_copy(0), 2'b01, 2'b01, 0, 0);
    check_idle("after_abort");
  endtask

  task automatic test_all_high();
    run_recovery("all_high", make_copy(32), 2'b10, 2'b10, 0, 0);
    check_idle("all_high");
  endtask

  task automatic test_back_to_back();
    run_recovery("b2b_first", make_copy(0), 2'b01, 2'b01, 0, 0);
    run_recovery("b2b_second", make_copy(32), 2'b11, 2'b11, 0, 0);
    check_idle("b2b");
  endtask

  task automatic test_random();
    logic [S-1:0] v, m;
    int j;
    for (int n = 0; n < 4; n++) begin
      v = S'($urandom);
      m = S'($urandom);
      j = $urandom_range(0, S - 1);
      v[j] = 1'b1;
      m[j] = 1'b1;
      run_recovery("random", rand_copy(), v, m, 0, 0);
    end
    check_idle("random");
  endtask

  initial begin
    test_reset();
    test_wen_idle();
    test_identity();
    test_older_mispredict();
    test_bypass();
    test_scan_ignores_retire();
    test_abort();
    test_all_high();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rrat_recovery_ctrl.md
# rrat_recovery_ctrl

Branch-mispredict recovery sequencer for the retirement rename table (RRAT). Gates per-slot RRAT write enables at retire and fires the RRAT rollback. It then rebuilds the physical-register free list from the committed mapping, scanning SCALAR registers per cycle, and holds dispatch stalled until recovery completes. Sits between the ROB retire ports, the RRAT, the front-end RAT and the free list.

## Interface
Parameters:
- SCALAR, 2, retire width; physical registers scanned per cycle.
- NUM_ENTRIES, 32, architectural registers (RRAT entries).
- NUM_PREGS, 64, physical registers; must be a multiple of SCALAR.
- PREG_IDX_WIDTH, 6, physical tag width, equal to $clog2(NUM_PREGS).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- retire_valid  in  SCALAR  ROB retire slot valid; slot 0 is oldest.
- retire_mispredict  in  SCALAR  retiring slot is a mispredicted branch.
- rrat_write_en  out  SCALAR  gated RRAT write enable per slot.
- rollback  out  1  RRAT rollback request; RRAT copy is valid this cycle.
- rrat_tag_copy  in  NUM_ENTRIES*PREG_IDX_WIDTH  RRAT copy; entry i is at [i*PREG_IDX_WIDTH +: PREG_IDX_WIDTH].
- rat_restore_en  out  1  RAT loads rrat_tag_copy this cycle.
- squash  out  1  flush all in-flight work.
- freelist_clear  out  1  free list empties at this clock edge.
- freelist_push_valid  out  SCALAR  lane k pushes freelist_push_tag[k].
- freelist_push_tag  out  SCALAR*PREG_IDX_WIDTH  lane k tag is at [k*PREG_IDX_WIDTH +: PREG_IDX_WIDTH].
- stall_dispatch  out  1  block rename/dispatch.
- recovery_done  out  1  single-cycle completion pulse.

## Operation
- States: IDLE, SCAN, DONE.
- trigger = (state==IDLE) & |(retire_valid & retire_mispredict).
- rrat_write_en[j] = retire_valid[j] & no older slot i<j has retire_valid[i]&retire_mispredict[i]. The mispredicting slot itself writes.
  - In SCAN/DONE, rrat_write_en is forced to 0. The ROB is flushed, so retire inputs there are ignored.
- On trigger (combinational, same cycle):
  - rollback, rat_restore_en, squash and freelist_clear are driven to 1.
  - stall_dispatch is driven to 1.
  - At the clock edge, the controller captures an occupancy bitmap used[NUM_PREGS]: used[p]=1 iff some entry of rrat_tag_copy equals p.
  - State goes to SCAN and scan_ptr is set to 0.
- SCAN:
  - Lane k examines p = scan_ptr+k.
  - freelist_push_valid[k] = !used[p]; the pushed tag is p.
  - scan_ptr advances by SCALAR each cycle.
  - When scan_ptr+SCALAR == NUM_PREGS, the next state is DONE.
- DONE: recovery_done=1 for one cycle, then state goes to IDLE.
- stall_dispatch = trigger | (state!=IDLE).
- Pushed tags are strictly increasing over a recovery. Total pushes equal NUM_PREGS minus the number of distinct tags in the copy.
- Duplicate tags in the copy count once; this is an illegal mapping but must not break the scan.

## Timing
- Reset: state=IDLE, scan_ptr=0, used=0. Every output is 0 in the cycle after reset is sampled.
  - rrat_write_en still follows retire inputs combinationally while in IDLE.
- Reset asserted mid-SCAN or mid-DONE aborts recovery. The next cycle is IDLE with no pushes and no recovery_done.
- Trigger at cycle T:
  - SCAN occupies T+1..T+NUM_PREGS/SCALAR.
  - DONE is at T+NUM_PREGS/SCALAR+1; this is T+33 at the defaults.
  - stall_dispatch deasserts at T+NUM_PREGS/SCALAR+2.
- A trigger is accepted again in the first IDLE cycle after DONE.
- All scan outputs are registered-state-derived (state, scan_ptr, used). Only the trigger-cycle pulses and rrat_write_en are combinational from retire inputs.

## Test plan
- Reset RRAT identity map (arch i→preg i). Retire slot0 valid+mispredict. Expected: rollback/rat_restore_en/squash/freelist_clear=1 at T. Pushes are tags 32..63, two per cycle, in T+17..T+32; none before T+17. recovery_done at T+33; stall low at T+34.
- Slot0 valid+mispredict with slot1 valid. Expected: rrat_write_en=2'b01.
- Slot0 normal and slot1 mispredict, writing arch 5→tag 40. Expected: rrat_write_en=2'b11. Via the RRAT bypass, tag 40 is not pushed and tag 5 is pushed.
- Retire mispredict presented during SCAN. Expected: rrat_write_en=0, no new rollback, scan sequence unchanged.
- Reset asserted at T+10. Expected: push_valid=0 and stall=0 from T+11; no recovery_done. A fresh trigger afterwards completes normally.
- Copy with all 32 entries mapped to 32..63. Expected: exactly tags 0..31 pushed, in T+1..T+16.
